// File: rtl/register_bank_w_mode.sv
// Purpose : multi-lane permutation state register with per-lane enables, masked load/xor-absorb and clear.
// Latency : one cycle; every output is a flop, no combinational path from inputs to outputs.
// Backpressure: none; an operation is accepted on every rising edge of clock_i.
//
// Ports:
//   clock_i      clock
//   resetb_i     asynchronous active-low reset
//   en_i         per-lane enable, bit k selects lane k
//   mode_i       00 hold, 01 masked load, 10 masked xor, 11 clear
//   byte_mask_i  bit j covers bits [8j+7:8j] of every lane (load/xor only)
//   data_i       input state, lane 0 at the MSBs
//   data_o       registered state, same lane mapping as data_i
//   lane_wr_o    sticky per-lane "written since clear" flags
//   wr_cnt_o     saturating count of accepted write cycles
//   all_wr_o     high when every lane_wr_o bit is set
module register_bank_w_mode #(
  parameter int LANE_W   = 64,  // multiple of 8
  parameter int NB_LANES = 5,
  parameter int CNT_W    = 8
) (
  input  logic                         clock_i,
  input  logic                         resetb_i,
  input  logic [NB_LANES-1:0]          en_i,
  input  logic [1:0]                   mode_i,
  input  logic [LANE_W/8-1:0]          byte_mask_i,
  input  logic [NB_LANES*LANE_W-1:0]   data_i,
  output logic [NB_LANES*LANE_W-1:0]   data_o,
  output logic [NB_LANES-1:0]          lane_wr_o,
  output logic [CNT_W-1:0]             wr_cnt_o,
  output logic                         all_wr_o
);

  localparam int NB_BYTES = LANE_W / 8;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_XOR   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // State registers
  logic [NB_LANES*LANE_W-1:0] data_q,    data_d;
  logic [NB_LANES-1:0]        lane_wr_q, lane_wr_d;
  logic [CNT_W-1:0]           wr_cnt_q,  wr_cnt_d;
  logic                       all_wr_q,  all_wr_d;

  // Decoded operation
  logic                is_write;
  logic                full_clear;
  logic [LANE_W-1:0]   bit_mask;

  // Byte mask expanded to one bit per lane bit; shared by all lanes.
  always_comb begin
    bit_mask = '0;
    for (int j = 0; j < NB_BYTES; j++) begin
      bit_mask[8*j +: 8] = {8{byte_mask_i[j]}};
    end
  end

  // A write cycle counts even with an all-zero byte mask: the control FSM
  // uses that to account for empty final blocks.
  assign is_write   = ((mode_i == MODE_LOAD) || (mode_i == MODE_XOR)) && (|en_i);
  assign full_clear = (mode_i == MODE_CLEAR) && (&en_i);

  // Per-lane datapath and written flags
  always_comb begin
    logic [LANE_W-1:0] lane_cur;
    logic [LANE_W-1:0] lane_in;

    data_d    = data_q;
    lane_wr_d = lane_wr_q;
    lane_cur  = '0;
    lane_in   = '0;

    for (int k = 0; k < NB_LANES; k++) begin
      // Lane 0 sits at the MSBs of the flat bus.
      lane_cur = data_q[(NB_LANES-k)*LANE_W-1 -: LANE_W];
      lane_in  = data_i[(NB_LANES-k)*LANE_W-1 -: LANE_W];

      if (en_i[k]) begin
        case (mode_i)
          MODE_HOLD: begin
            data_d[(NB_LANES-k)*LANE_W-1 -: LANE_W] = lane_cur;
          end
          MODE_LOAD: begin
            data_d[(NB_LANES-k)*LANE_W-1 -: LANE_W] =
              (lane_in & bit_mask) | (lane_cur & ~bit_mask);
            lane_wr_d[k] = 1'b1;
          end
          MODE_XOR: begin
            data_d[(NB_LANES-k)*LANE_W-1 -: LANE_W] = lane_cur ^ (lane_in & bit_mask);
            lane_wr_d[k] = 1'b1;
          end
          MODE_CLEAR: begin
            data_d[(NB_LANES-k)*LANE_W-1 -: LANE_W] = '0;
            lane_wr_d[k] = 1'b0;
          end
          default: begin
            data_d[(NB_LANES-k)*LANE_W-1 -: LANE_W] = lane_cur;
          end
        endcase
      end
    end
  end

  // Saturating write counter; only a clear of every lane restarts it, so a
  // partial clear does not disturb absorb/squeeze sequencing.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (full_clear) begin
      wr_cnt_d = '0;
    end else if (is_write && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + CNT_ONE;
    end
  end

  // Built from the next-state flags so it moves in the same cycle as lane_wr_o.
  assign all_wr_d = &lane_wr_d;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      data_q    <= '0;
      lane_wr_q <= '0;
      wr_cnt_q  <= '0;
      all_wr_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      lane_wr_q <= lane_wr_d;
      wr_cnt_q  <= wr_cnt_d;
      all_wr_q  <= all_wr_d;
    end
  end

  assign data_o    = data_q;
  assign lane_wr_o = lane_wr_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign all_wr_o  = all_wr_q;

endmodule
